// File: rtl/avg_seq_pkg.sv
// Shared types for the averaging-filter sequencer: FSM states, frame type
// and the filter latency helper.
package avg_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BYPASS = 3'd1,
    RUN    = 3'd2,
    CAPT   = 3'd3,
    OUT    = 3'd4
  } state_t;

  localparam int R_I_DEF = 16;
  localparam int C_I_DEF = 16;
  localparam int W_I_DEF = 8;

  typedef logic [R_I_DEF-1:0][C_I_DEF-1:0][W_I_DEF-1:0] frame_t;

  // Adder-tree depth over the kernel window plus the output register.
  function automatic int filt_latency(input int rk, input int ck);
    return $clog2(rk * ck) + 1;
  endfunction

endpackage

// File: rtl/avg_seq_counter.sv
// Latency and pass counters for the averaging-filter sequencer, with
// terminal-count flags for the last enabled cycle and the last pass.
module avg_seq_counter #(
  parameter  int LAT    = 5,
  parameter  int PASS_W = 4,
  localparam int LAT_W  = $clog2(LAT + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr_i,
  input  logic              lat_inc_i,
  input  logic              lat_clr_i,
  input  logic              pass_inc_i,
  input  logic [PASS_W-1:0] pass_tgt_i,
  output logic [LAT_W-1:0]  lat_cnt_o,
  output logic              last_lat_o,
  output logic              last_pass_o
);

  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;

  always_comb begin
    lat_cnt_d  = lat_cnt_q;
    pass_cnt_d = pass_cnt_q;
    if (clr_i) begin
      lat_cnt_d  = '0;
      pass_cnt_d = '0;
    end else begin
      if (lat_clr_i)      lat_cnt_d = '0;
      else if (lat_inc_i) lat_cnt_d = lat_cnt_q + LAT_W'(1);
      if (pass_inc_i)     pass_cnt_d = pass_cnt_q + PASS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lat_cnt_q  <= '0;
      pass_cnt_q <= '0;
    end else begin
      lat_cnt_q  <= lat_cnt_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end

  assign lat_cnt_o   = lat_cnt_q;
  assign last_lat_o  = (lat_cnt_q == LAT_W'(LAT - 1));
  assign last_pass_o = (pass_cnt_q == (pass_tgt_i - PASS_W'(1)));

endmodule

// File: rtl/avg_filter_sequencer.sv
// Sequences the fully parallel averaging filter: accept a frame, run n_pass
// enabled bursts of LAT cycles, then present the result. AVG_SEQ_PERF_EN adds
// frame_cnt / last_cycles performance outputs.
module avg_filter_sequencer
  import avg_seq_pkg::*;
#(
  parameter int R_I    = 16,
  parameter int C_I    = 16,
  parameter int W_I    = 8,
  parameter int R_K    = 3,
  parameter int C_K    = 3,
  parameter int PASS_W = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [R_I*C_I*W_I-1:0] in_img,
  input  logic [PASS_W-1:0]      n_pass,
  input  logic                   flush,
  output logic                   filt_cen,
  output logic [R_I*C_I*W_I-1:0] filt_img,
  input  logic [R_I*C_I*W_I-1:0] filt_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [R_I*C_I*W_I-1:0] out_img,
  output logic                   busy
`ifdef AVG_SEQ_PERF_EN
  ,
  output logic [15:0]            frame_cnt,
  output logic [15:0]            last_cycles
`endif
);

  localparam int LAT   = filt_latency(R_K, C_K);
  localparam int LAT_W = $clog2(LAT + 1);
  localparam int FW    = R_I * C_I * W_I;

  // Handshakes: a transfer happens on the rising clk edge where valid and
  // ready are both high; valid, once raised, holds with stable data until then.
  state_t            state_q, state_d;
  logic [FW-1:0]     img_q, out_img_q;
  logic [PASS_W-1:0] pass_tgt_q;
  logic [LAT_W-1:0]  lat_cnt;
  logic              last_lat, last_pass;
  logic              accept, reload, cap_out, byp_copy;
  logic              lat_inc, lat_clr, pass_inc;

  avg_seq_counter #(.LAT(LAT), .PASS_W(PASS_W)) u_cnt (
    .clk        (clk),
    .rstn       (rstn),
    .clr_i      (accept | flush),
    .lat_inc_i  (lat_inc),
    .lat_clr_i  (lat_clr),
    .pass_inc_i (pass_inc),
    .pass_tgt_i (pass_tgt_q),
    .lat_cnt_o  (lat_cnt),
    .last_lat_o (last_lat),
    .last_pass_o(last_pass)
  );

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    reload   = 1'b0;
    cap_out  = 1'b0;
    byp_copy = 1'b0;
    lat_inc  = 1'b0;
    lat_clr  = 1'b0;
    pass_inc = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        accept  = 1'b1;
        state_d = (n_pass == '0) ? BYPASS : RUN;
      end
      // Held for two cycles so a zero-pass frame still appears two cycles
      // after accept.
      BYPASS: if (lat_cnt == LAT_W'(1)) begin
        byp_copy = 1'b1;
        lat_clr  = 1'b1;
        state_d  = OUT;
      end else begin
        lat_inc = 1'b1;
      end
      RUN: if (last_lat) begin
        lat_clr = 1'b1;
        state_d = CAPT;
      end else begin
        lat_inc = 1'b1;
      end
      CAPT: if (last_pass) begin
        cap_out = 1'b1;
        state_d = OUT;
      end else begin
        reload   = 1'b1;
        pass_inc = 1'b1;
        state_d  = RUN;
      end
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d  = IDLE;
      accept   = 1'b0;
      reload   = 1'b0;
      cap_out  = 1'b0;
      byp_copy = 1'b0;
      lat_inc  = 1'b0;
      pass_inc = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      img_q      <= '0;
      out_img_q  <= '0;
      pass_tgt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        img_q      <= in_img;
        pass_tgt_q <= n_pass;
      end else if (reload) begin
        img_q <= filt_result;
      end
      if (cap_out)       out_img_q <= filt_result;
      else if (byp_copy) out_img_q <= img_q;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign filt_cen  = (state_q == RUN);
  assign out_valid = (state_q == OUT);
  assign filt_img  = img_q;
  assign out_img   = out_img_q;

`ifdef AVG_SEQ_PERF_EN
  logic [15:0] frame_cnt_q, last_cycles_q, cyc_q;

  // cyc_q equals the number of edges since accept, so it is latched on OUT entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt_q   <= '0;
      last_cycles_q <= '0;
      cyc_q         <= '0;
    end else begin
      if (out_valid && out_ready && frame_cnt_q != 16'hFFFF)
        frame_cnt_q <= frame_cnt_q + 16'd1;
      if (accept)
        cyc_q <= 16'd1;
      else if (flush)
        cyc_q <= '0;
      else if (state_q != IDLE && cyc_q != 16'hFFFF)
        cyc_q <= cyc_q + 16'd1;
      if (state_d == OUT && state_q != OUT)
        last_cycles_q <= cyc_q;
    end
  end

  assign frame_cnt   = frame_cnt_q;
  assign last_cycles = last_cycles_q;
`endif

endmodule

// File: tb/tb_avg_filter_sequencer.sv
// Directed bench for avg_filter_sequencer with a behavioural LAT-cycle box
// filter standing in for the datapath.
module tb_avg_filter_sequencer;

  localparam int R   = 16;
  localparam int C   = 16;
  localparam int W   = 8;
  localparam int PW  = 4;
  localparam int LAT = 5;

  typedef logic [R-1:0][C-1:0][W-1:0] frame_t;

  typedef struct {
    int n_pass;
    int pattern;
    int exp_lat;
    int exp_cen;
    int r0, c0, v0;
    int r1, c1, v1;
    int r2, c2, v2;
  } vec_t;

  logic          clk;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  frame_t        in_img;
  logic [PW-1:0] n_pass;
  logic          flush;
  logic          filt_cen;
  frame_t        filt_img;
  frame_t        res_q = '0;
  logic          out_valid;
  logic          out_ready;
  frame_t        out_img;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int cen_seen = 0;
  int mcnt;

  avg_filter_sequencer dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_img     (in_img),
    .n_pass     (n_pass),
    .flush      (flush),
    .filt_cen   (filt_cen),
    .filt_img   (filt_img),
    .filt_result(res_q),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_img    (out_img),
    .busy       (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic frame_t blur(input frame_t f);
    frame_t o;
    int s, rr, cc;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        s = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (rr >= 0 && rr < R && cc >= 0 && cc < C) s += int'(f[rr][cc]);
          end
        end
        o[r][c] = W'(s / 9);
      end
    end
    return o;
  endfunction

  function automatic frame_t make_frame(input int pattern);
    frame_t f;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        f[r][c] = (pattern == 0) ? W'(50) : W'(r * 16 + c);
    return f;
  endfunction

  // Datapath stand-in: result appears after LAT enabled edges.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mcnt <= 0;
    end else if (flush) begin
      mcnt <= 0;
    end else if (filt_cen) begin
      if (mcnt == LAT - 1) begin
        res_q <= blur(filt_img);
        mcnt  <= 0;
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  always @(negedge clk) if (filt_cen === 1'b1) cen_seen++;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_img(input string name, input frame_t act, input frame_t exp);
    int br, bc;
    checks++;
    if (act !== exp) begin
      failures++;
      br = -1;
      bc = -1;
      for (int r = R - 1; r >= 0; r--)
        for (int c = C - 1; c >= 0; c--)
          if (act[r][c] !== exp[r][c]) begin
            br = r;
            bc = c;
          end
      $display("FAIL %s pixel[%0d][%0d] actual=%0d required=%0d", name, br, bc,
               act[br][bc], exp[br][bc]);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic start_frame(input frame_t f, input int np);
    in_img   = f;
    n_pass   = PW'(np);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic handshake(input string name);
    @(posedge clk);
    #1;
    chk({name, " out_valid drop"}, 32'(out_valid), 0);
    chk({name, " in_ready back"}, 32'(in_ready), 1);
  endtask

  // ---------------- test ----------------
  vec_t   vecs[5];
  frame_t f, exp_out, exp_filt;
  int     lat, c0;
  logic   seen;

  initial begin
    vecs[0] = '{1, 0, 6, 5,    0, 0, 22,   0, 7, 33,   8, 8, 50};
    vecs[1] = '{2, 0, 12, 10,  0, 0, 15,   0, 7, 27,   8, 8, 50};
    vecs[2] = '{0, 1, 2, 0,    0, 0, 0,    15, 15, 255, 3, 4, 52};
    vecs[3] = '{1, 1, 6, 5,    0, 0, 3,    8, 8, 136,  15, 15, 109};
    vecs[4] = '{3, 0, 18, 15,  8, 8, 50,   5, 5, 50,   7, 9, 50};

    rstn      = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    n_pass    = '0;
    in_img    = '0;
    #2;
    chk("reset in_ready", 32'(in_ready), 1);
    chk("reset busy", 32'(busy), 0);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset filt_cen", 32'(filt_cen), 0);
    chk_img("reset out_img", out_img, '0);
    chk_img("reset filt_img", filt_img, '0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven frames with out_ready held high.
    for (int i = 0; i < 5; i++) begin
      f        = make_frame(vecs[i].pattern);
      exp_out  = f;
      exp_filt = f;
      for (int p = 0; p < vecs[i].n_pass; p++) exp_out = blur(exp_out);
      for (int p = 1; p < vecs[i].n_pass; p++) exp_filt = blur(exp_filt);
      chk($sformatf("v%0d in_ready idle", i), 32'(in_ready), 1);
      c0 = cen_seen;
      start_frame(f, vecs[i].n_pass);
      wait_out(40, lat);
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d filt_cen cycles", i), 32'(cen_seen - c0), 32'(vecs[i].exp_cen));
      chk_img($sformatf("v%0d out_img", i), out_img, exp_out);
      chk_img($sformatf("v%0d filt_img", i), filt_img, exp_filt);
      chk($sformatf("v%0d pix0", i), 32'(out_img[vecs[i].r0][vecs[i].c0]), 32'(vecs[i].v0));
      chk($sformatf("v%0d pix1", i), 32'(out_img[vecs[i].r1][vecs[i].c1]), 32'(vecs[i].v1));
      chk($sformatf("v%0d pix2", i), 32'(out_img[vecs[i].r2][vecs[i].c2]), 32'(vecs[i].v2));
      chk($sformatf("v%0d busy in OUT", i), 32'(busy), 1);
      handshake($sformatf("v%0d", i));
    end

    // Output stall: out_valid/out_img hold, new frames are refused.
    f         = make_frame(1);
    exp_out   = blur(f);
    out_ready = 1'b0;
    start_frame(f, 1);
    wait_out(40, lat);
    chk("stall latency", 32'(lat), 6);
    in_img   = make_frame(0);
    n_pass   = '0;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("stall out_valid", 32'(out_valid), 1);
      chk("stall in_ready", 32'(in_ready), 0);
      chk_img("stall out_img", out_img, exp_out);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    handshake("stall");
    chk_img("stall frame not taken", filt_img, f);
    chk("stall busy after", 32'(busy), 0);

    // Flush in the middle of RUN.
    start_frame(make_frame(0), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("flush pre filt_cen", 32'(filt_cen), 1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush busy", 32'(busy), 0);
    chk("flush filt_cen", 32'(filt_cen), 0);
    chk("flush in_ready", 32'(in_ready), 1);
    chk_img("flush out_img kept", out_img, exp_out);
    c0   = cen_seen;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush no out_valid", 32'(seen), 0);
    chk("flush no filt_cen", 32'(cen_seen - c0), 0);

    // Flush coincident with in_valid blocks the accept.
    in_img   = make_frame(0);
    n_pass   = PW'(1);
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("flush+valid busy", 32'(busy), 0);

    f = make_frame(1);
    start_frame(f, 1);
    wait_out(40, lat);
    chk("post-flush latency", 32'(lat), 6);
    chk_img("post-flush out_img", out_img, blur(f));
    handshake("post-flush");

    // Asynchronous reset during the first CAPT of a three-pass frame.
    start_frame(make_frame(0), 3);
    repeat (5) @(posedge clk);
    #1;
    chk("capt filt_cen", 32'(filt_cen), 0);
    chk("capt busy", 32'(busy), 1);
    rstn = 1'b0;
    #1;
    chk("mid-reset in_ready", 32'(in_ready), 1);
    chk("mid-reset busy", 32'(busy), 0);
    chk("mid-reset filt_cen", 32'(filt_cen), 0);
    chk("mid-reset out_valid", 32'(out_valid), 0);
    chk_img("mid-reset out_img", out_img, '0);
    chk_img("mid-reset filt_img", filt_img, '0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    f = make_frame(1);
    start_frame(f, 1);
    wait_out(40, lat);
    chk("post-reset latency", 32'(lat), 6);
    chk_img("post-reset out_img", out_img, blur(f));
    handshake("post-reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
